spart: RTL

- Special-purpose asynchronous receiver/transmitter that responds to the processor-side bus: chip select, read/write, 2-bit address, bidirectional 8-bit data bus.
- Provides a TX buffer, an RX buffer, a status register, and a programmable 16-bit baud divisor.
- Serialises 8N1 frames on txd and deserialises 8N1 frames from rxd, using 16x oversampling.
- Sits between the bus-master driver FSM and the board serial pins.

---
 rtl/spart_pkg.sv | 26 ++
 rtl/spart_baud_gen.sv | 34 +++
 rtl/spart.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared constants and FSM state types for the spart UART
// Purpose: bus register addresses, oversampling constants, TX/RX state enums.
// Ports: none (package).
package spart_pkg;

    localparam logic [1:0] ADDR_BUF    = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DBL    = 2'b10;
    localparam logic [1:0] ADDR_DBH    = 2'b11;

    localparam int OVERSAMPLE = 16;
    localparam int HALF_BIT   = 8;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// rtl/spart_baud_gen.sv - programmable 16x oversampling tick generator
// Purpose: down counter that pulses en16 once every max(db,1) clock cycles.
// Ports: clk, rst (async high), db (divisor), restart (reload now), en16 (tick).
module spart_baud_gen #(
    parameter logic [15:0] DB_RESET = 16'd651
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] db,
    input  logic        restart,
    output logic        en16
);

    logic [15:0] cnt_q, cnt_d;

    // Pulsing at count 1 (or 0) gives a period of db cycles, and db=0
    // falls into the same branch every cycle, i.e. behaves as db=1.
    always_comb begin
        en16  = 1'b0;
        cnt_d = cnt_q - 16'd1;
        if (restart) begin
            cnt_d = db;
        end else if (cnt_q <= 16'd1) begin
            en16  = 1'b1;
            cnt_d = db;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= DB_RESET;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/spart.sv
// rtl/spart.sv - bus-mapped 8N1 UART with 16x oversampled receiver
// Purpose: TX/RX buffers, status register, programmable baud divisor.
// Ports: clk, rst (async high), iocs/iorw/ioaddr/databus (processor bus),
//        rda/tbr (status), txd (serial out), rxd (serial in, async).
module spart
    import spart_pkg::*;
#(
    parameter logic [15:0] DB_RESET    = 16'd651,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    logic       rd_en, wr_en;
    logic [7:0] rd_data;
    logic [15:0] db_q, db_d;
    logic       db_restart, en16;

    tx_state_t  tx_state_q, tx_state_d;
    logic [9:0] tx_shift_q, tx_shift_d;
    logic [3:0] tx_tick_q, tx_tick_d;
    logic [3:0] tx_bit_q, tx_bit_d;
    logic       txd_q, txd_d, tbr_q, tbr_d;

    logic [SYNC_STAGES-1:0] rxd_sync_q, rxd_sync_d;
    logic       rxd_s;
    rx_state_t  rx_state_q, rx_state_d;
    logic [3:0] rx_tick_q, rx_tick_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d, rx_buf_q, rx_buf_d;
    logic       rda_q, rda_d, fe_q, fe_d, set_rda, set_fe;

    assign rd_en = iocs && iorw;
    assign wr_en = iocs && !iorw;

    always_comb begin
        case (ioaddr)
            ADDR_BUF:    rd_data = rx_buf_q;
            ADDR_STATUS: rd_data = {5'b0, fe_q, tbr_q, rda_q};
            ADDR_DBL:    rd_data = db_q[7:0];
            default:     rd_data = db_q[15:8];
        endcase
    end

    assign databus = rd_en ? rd_data : 8'bz;

    always_comb begin
        db_d       = db_q;
        db_restart = 1'b0;
        if (wr_en && ioaddr == ADDR_DBL) begin
            db_d[7:0]  = databus;
            db_restart = 1'b1;
        end else if (wr_en && ioaddr == ADDR_DBH) begin
            db_d[15:8] = databus;
            db_restart = 1'b1;
        end
    end

    // Fed db_d so a divisor write reloads the counter with the new value.
    spart_baud_gen #(.DB_RESET(DB_RESET)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .db      (db_d),
        .restart (db_restart),
        .en16    (en16)
    );

    // Transmitter: txd drops on the load edge, so the start bit's first
    // tick period is partial.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        txd_d      = txd_q;
        tbr_d      = tbr_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (wr_en && ioaddr == ADDR_BUF) begin
                    tx_shift_d = {1'b1, databus, 1'b0};
                    txd_d      = 1'b0;
                    tbr_d      = 1'b0;
                    tx_tick_d  = 4'd0;
                    tx_bit_d   = 4'd0;
                    tx_state_d = TX_SHIFT;
                end
            end
            default: begin
                if (en16) begin
                    if (tx_tick_q == 4'(OVERSAMPLE - 1)) begin
                        tx_tick_d = 4'd0;
                        if (tx_bit_q == 4'd9) begin
                            tx_state_d = TX_IDLE;
                            tbr_d      = 1'b1;
                            txd_d      = 1'b1;
                        end else begin
                            tx_shift_d = {1'b1, tx_shift_q[9:1]};
                            txd_d      = tx_shift_q[1];
                            tx_bit_d   = tx_bit_q + 4'd1;
                        end
                    end else begin
                        tx_tick_d = tx_tick_q + 4'd1;
                    end
                end
            end
        endcase
    end

    assign rxd_sync_d = {rxd_sync_q[SYNC_STAGES-2:0], rxd};
    assign rxd_s      = rxd_sync_q[SYNC_STAGES-1];

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_buf_d   = rx_buf_q;
        set_rda    = 1'b0;
        set_fe     = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rxd_s) begin
                    rx_state_d = RX_START;
                    rx_tick_d  = 4'd0;
                end
            end
            RX_START: begin
                if (en16) begin
                    if (rx_tick_q == 4'(HALF_BIT - 1)) begin
                        // Still low at mid start bit: genuine frame.
                        rx_tick_d  = 4'd0;
                        rx_bit_d   = 3'd0;
                        rx_state_d = rxd_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tick_d = rx_tick_q + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (en16) begin
                    if (rx_tick_q == 4'(OVERSAMPLE - 1)) begin
                        rx_tick_d  = 4'd0;
                        rx_shift_d = {rxd_s, rx_shift_q[7:1]};
                        rx_bit_d   = rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    end else begin
                        rx_tick_d = rx_tick_q + 4'd1;
                    end
                end
            end
            default: begin
                if (en16) begin
                    if (rx_tick_q == 4'(OVERSAMPLE - 1)) begin
                        rx_tick_d  = 4'd0;
                        rx_state_d = RX_IDLE;
                        if (rxd_s) begin
                            rx_buf_d = rx_shift_q;
                            set_rda  = 1'b1;
                        end else begin
                            set_fe = 1'b1;
                        end
                    end else begin
                        rx_tick_d = rx_tick_q + 4'd1;
                    end
                end
            end
        endcase
    end

    // Read-to-clear, with a same-edge set taking priority.
    always_comb begin
        rda_d = rda_q;
        fe_d  = fe_q;
        if (rd_en && ioaddr == ADDR_BUF)    rda_d = 1'b0;
        if (rd_en && ioaddr == ADDR_STATUS) fe_d  = 1'b0;
        if (set_rda) rda_d = 1'b1;
        if (set_fe)  fe_d  = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q       <= DB_RESET;
            tx_state_q <= TX_IDLE;
            tx_shift_q <= 10'h3ff;
            tx_tick_q  <= 4'd0;
            tx_bit_q   <= 4'd0;
            txd_q      <= 1'b1;
            tbr_q      <= 1'b1;
            rxd_sync_q <= '1;
            rx_state_q <= RX_IDLE;
            rx_tick_q  <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_buf_q   <= 8'h00;
            rda_q      <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            db_q       <= db_d;
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            txd_q      <= txd_d;
            tbr_q      <= tbr_d;
            rxd_sync_q <= rxd_sync_d;
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_buf_q   <= rx_buf_d;
            rda_q      <= rda_d;
            fe_q       <= fe_d;
        end
    end

    assign txd = txd_q;
    assign tbr = tbr_q;
    assign rda = rda_q;

endmodule
